rr_arbiter_2to1: RTL

RR_ARBITER_2TO1 -- requirements
Module: rr_arbiter_2to1

---
 rtl/rr_arbiter_2to1.sv | 106 ++++++++++
 1 files changed

// File: rtl/rr_arbiter_2to1.sv
// Two-requester round-robin arbiter with a one-entry registered output stage.
// Both requesters are valid: the one that did not win last time gets the grant.
module rr_arbiter_2to1 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             sel,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic             r_src;
    logic             r_prio;
    logic             r_sel;
    logic [15:0]      r_cnt0;
    logic [15:0]      r_cnt1;

    logic             w_grant;
    logic             w_win;
    logic             w_free;
    logic             w_acc;
    logic [WIDTH-1:0] w_mux_data;

    always_comb begin
        w_grant   = in0_valid | in1_valid;
        w_win     = (in0_valid & in1_valid) ? ~r_prio : in1_valid;
        // Free also when full and draining, so a new word can land in the same cycle.
        w_free    = (r_state == EMPTY) | out_ready;
        in0_ready = ~reset & w_grant & ~w_win & w_free;
        in1_ready = ~reset & w_grant &  w_win & w_free;
        w_acc     = (in0_valid & in0_ready) | (in1_valid & in1_ready);
        sel       = w_grant ? w_win : r_sel;
        w_mux_data = sel ? in1_data : in0_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            w_state_nxt = FULL;
        end else if ((r_state == FULL) && out_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_src  <= 1'b0;
            r_prio <= 1'b1;
            r_sel  <= 1'b0;
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_grant) begin
                r_sel <= w_win;
            end
            if (w_acc) begin
                r_data <= w_mux_data;
                r_src  <= w_win;
                r_prio <= w_win;
                // Counters saturate rather than wrap.
                if (w_win) begin
                    if (r_cnt1 != 16'hFFFF) r_cnt1 <= r_cnt1 + 16'd1;
                end else begin
                    if (r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
                end
            end
        end
    end

    always_comb begin
        out_valid = (r_state == FULL);
        out_data  = r_data;
        out_src   = r_src;
        cnt0      = r_cnt0;
        cnt1      = r_cnt1;
    end

endmodule
